// File: rtl/pe_ws_dbuf.sv
// pe_ws_dbuf: weight-stationary systolic-array processing element with
// double-buffered weights.
//
// Each PE holds an "active" weight used by the MAC and a "shadow" weight that
// forms a top-to-bottom shift chain, so the next tile's weights stream in while
// the current tile computes. The MAC has one cycle of latency. It can run signed
// or unsigned, and it either saturates or wraps. A sticky flag records any clamp
// or wrap.
//
// Parameters
//   DATA_W  ifmap/weight width (2..16)
//   PSUM_W  psum width (>= 2*DATA_W)
//   SIGNED  1: two's-complement operands and psum, 0: unsigned
//   SAT     1: clamp to the PSUM_W range, 0: wrap modulo 2^PSUM_W
//
// Ports
//   iClk, iRest             clock; synchronous active-high reset
//   iW_in, iW_load, iW_swap weight chain input, shift-in and shadow->active copy
//   iIfmap, iVld, iPsum     MAC operands from left/above, with their valid
//   iClr_ovf                clears the sticky overflow flag
//   oW_out                  shadow weight to the PE below
//   oIfmap, oIfmap_vld      registered ifmap to the right neighbour
//   oPsum, oPsum_vld        registered MAC result to the PE below
//   oOvf                    sticky overflow (clamp or wrap happened)
module pe_ws_dbuf #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic              iClk,
  input  logic              iRest,
  input  logic [DATA_W-1:0] iW_in,
  input  logic              iW_load,
  input  logic              iW_swap,
  input  logic [DATA_W-1:0] iIfmap,
  input  logic              iVld,
  input  logic [PSUM_W-1:0] iPsum,
  input  logic              iClr_ovf,
  output logic [DATA_W-1:0] oW_out,
  output logic [DATA_W-1:0] oIfmap,
  output logic              oIfmap_vld,
  output logic [PSUM_W-1:0] oPsum,
  output logic              oPsum_vld,
  output logic              oOvf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PSUM_W + 1;

  if ((DATA_W < 2) || (DATA_W > 16) || (PSUM_W < 2 * DATA_W)) begin : g_param_err
    $error("pe_ws_dbuf: illegal DATA_W/PSUM_W combination");
  end

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic [DATA_W-1:0] ifmap_q, ifmap_d;
  logic              ifmap_vld_q, ifmap_vld_d;
  logic [PSUM_W-1:0] psum_q, psum_d;
  logic              psum_vld_q, psum_vld_d;
  logic              ovf_q, ovf_d;

  logic [PROD_W-1:0] w_ext_s, x_ext_s, prod_s;
  logic [SUM_W-1:0]  prod_ext_s, psum_ext_s, sum_s;
  logic              sum_ovf_s;
  logic [PSUM_W-1:0] mac_res_s;

  // MAC datapath: product, widened sum, range detection and clamp/wrap
  always_comb begin
    // Extending both operands to PROD_W makes a plain PROD_W-bit multiply
    // correct for signed and unsigned alike (the true product fits exactly).
    w_ext_s    = {{DATA_W{SIGNED & active_q[DATA_W-1]}}, active_q};
    x_ext_s    = {{DATA_W{SIGNED & iIfmap[DATA_W-1]}}, iIfmap};
    prod_s     = w_ext_s * x_ext_s;
    prod_ext_s = {{(SUM_W-PROD_W){SIGNED & prod_s[PROD_W-1]}}, prod_s};
    psum_ext_s = {SIGNED & iPsum[PSUM_W-1], iPsum};
    sum_s      = prod_ext_s + psum_ext_s;

    // Out of range: signed when the two top bits disagree, unsigned on carry-out.
    if (SIGNED) begin
      sum_ovf_s = sum_s[SUM_W-1] ^ sum_s[SUM_W-2];
    end else begin
      sum_ovf_s = sum_s[SUM_W-1];
    end

    mac_res_s = sum_s[PSUM_W-1:0];
    if (SAT && sum_ovf_s) begin
      if (SIGNED) begin
        // Top bit of the widened sum is the true sign: negative -> min, else max.
        if (sum_s[SUM_W-1]) begin
          mac_res_s = {1'b1, {(PSUM_W-1){1'b0}}};
        end else begin
          mac_res_s = {1'b0, {(PSUM_W-1){1'b1}}};
        end
      end else begin
        mac_res_s = {PSUM_W{1'b1}};
      end
    end else begin
      mac_res_s = sum_s[PSUM_W-1:0];
    end
  end

  // Next-state for the weight buffers, output pipeline and sticky flag
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    ifmap_d     = ifmap_q;
    ifmap_vld_d = 1'b0;
    psum_d      = psum_q;
    psum_vld_d  = 1'b0;
    ovf_d       = ovf_q;

    // Swap reads the pre-load shadow, so load+swap gives active the old value.
    if (iW_swap) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
    if (iW_load) begin
      shadow_d = iW_in;
    end else begin
      shadow_d = shadow_q;
    end

    if (iVld) begin
      ifmap_d     = iIfmap;
      ifmap_vld_d = 1'b1;
      psum_d      = mac_res_s;
      psum_vld_d  = 1'b1;
    end else begin
      ifmap_vld_d = 1'b0;
      psum_vld_d  = 1'b0;
    end

    // A new overflow beats a simultaneous clear.
    if (iVld && sum_ovf_s) begin
      ovf_d = 1'b1;
    end else if (iClr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (iRest) begin
      shadow_q    <= {DATA_W{1'b0}};
      active_q    <= {DATA_W{1'b0}};
      ifmap_q     <= {DATA_W{1'b0}};
      ifmap_vld_q <= 1'b0;
      psum_q      <= {PSUM_W{1'b0}};
      psum_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      ifmap_q     <= ifmap_d;
      ifmap_vld_q <= ifmap_vld_d;
      psum_q      <= psum_d;
      psum_vld_q  <= psum_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  assign oW_out     = shadow_q;
  assign oIfmap     = ifmap_q;
  assign oIfmap_vld = ifmap_vld_q;
  assign oPsum      = psum_q;
  assign oPsum_vld  = psum_vld_q;
  assign oOvf       = ovf_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Bench for pe_ws_dbuf: three single-PE configurations sharing one stimulus
// stream, plus a four-PE weight chain. Expected values come from an
// integer-arithmetic model of the MAC rules.
module tb_pe_ws_dbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, w_load, w_swap, vld, clr;
  logic [7:0]  w_in, x;
  logic [23:0] p;

  // config A: 8/24 signed sat; B: 8/16 signed sat; C: 8/24 unsigned wrap
  logic [7:0]  woA, woB, woC, ifA, ifB, ifC;
  logic        ivA, ivB, ivC, pvA, pvB, pvC, ovA, ovB, ovC;
  logic [23:0] psA, psC;
  logic [15:0] psB;

  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1'b1), .SAT(1'b1)) u_a (
    .iClk(clk), .iRest(rst), .iW_in(w_in), .iW_load(w_load), .iW_swap(w_swap),
    .iIfmap(x), .iVld(vld), .iPsum(p), .iClr_ovf(clr), .oW_out(woA),
    .oIfmap(ifA), .oIfmap_vld(ivA), .oPsum(psA), .oPsum_vld(pvA), .oOvf(ovA));
  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(16), .SIGNED(1'b1), .SAT(1'b1)) u_b (
    .iClk(clk), .iRest(rst), .iW_in(w_in), .iW_load(w_load), .iW_swap(w_swap),
    .iIfmap(x), .iVld(vld), .iPsum(p[15:0]), .iClr_ovf(clr), .oW_out(woB),
    .oIfmap(ifB), .oIfmap_vld(ivB), .oPsum(psB), .oPsum_vld(pvB), .oOvf(ovB));
  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1'b0), .SAT(1'b0)) u_c (
    .iClk(clk), .iRest(rst), .iW_in(w_in), .iW_load(w_load), .iW_swap(w_swap),
    .iIfmap(x), .iVld(vld), .iPsum(p), .iClr_ovf(clr), .oW_out(woC),
    .oIfmap(ifC), .oIfmap_vld(ivC), .oPsum(psC), .oPsum_vld(pvC), .oOvf(ovC));

  // four-PE column: weight chain top->down, common ifmap, psum input 0
  logic        c_load, c_swap, c_vld;
  logic [7:0]  c_w, c_x;
  logic [7:0]  c_wch [0:4];
  logic [7:0]  c_ifo [0:3];
  logic        c_ifv [0:3];
  logic        c_pv  [0:3];
  logic        c_ov  [0:3];
  logic [23:0] c_ps  [0:3];
  assign c_wch[0] = c_w;

  for (genvar k = 0; k < 4; k++) begin : g_col
    pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1'b1), .SAT(1'b1)) u_pe (
      .iClk(clk), .iRest(rst), .iW_in(c_wch[k]), .iW_load(c_load), .iW_swap(c_swap),
      .iIfmap(c_x), .iVld(c_vld), .iPsum(24'd0), .iClr_ovf(1'b0), .oW_out(c_wch[k+1]),
      .oIfmap(c_ifo[k]), .oIfmap_vld(c_ifv[k]), .oPsum(c_ps[k]), .oPsum_vld(c_pv[k]),
      .oOvf(c_ov[k]));
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  int   cpw  [3] = '{24, 16, 24};
  bit   csg  [3] = '{1'b1, 1'b1, 1'b0};
  bit   csat [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0]  m_sh, m_act, m_ifm;
  logic        m_vld;
  logic [23:0] m_ps  [3];
  bit          m_ovf [3];

  // MAC rule in plain integer arithmetic
  function automatic void model_mac(input logic [7:0] w, input logic [7:0] xi,
                                    input logic [23:0] pi, input int pw, input bit sgn,
                                    input bit sat, output logic [23:0] res, output bit ovf);
    longint wv, xv, pv, s, lo, hi, m;
    m = (longint'(1) << pw) - 1;
    if (sgn) begin
      wv = longint'($signed(w));
      xv = longint'($signed(xi));
    end else begin
      wv = longint'(w);
      xv = longint'(xi);
    end
    pv = longint'(pi) & m;
    if (sgn && pv > (m >> 1)) pv = pv - (m + 1);
    s = wv * xv + pv;
    if (sgn) begin
      lo = -((m + 1) >> 1);
      hi = m >> 1;
    end else begin
      lo = 0;
      hi = m;
    end
    ovf = (s < lo) || (s > hi);
    if (ovf && sat) s = (s > hi) ? hi : lo;
    res = 24'(s & m);
  endfunction

  task automatic check_cfg(input string n, input int c, input logic [23:0] ps, input logic pv,
                           input logic [7:0] ifm, input logic iv, input logic ov,
                           input logic [7:0] wo);
    check({n, "_psum"},  32'(ps),  32'(m_ps[c]));
    check({n, "_pvld"},  32'(pv),  32'(m_vld));
    check({n, "_ifmap"}, 32'(ifm), 32'(m_ifm));
    check({n, "_ivld"},  32'(iv),  32'(m_vld));
    check({n, "_ovf"},   32'(ov),  32'(m_ovf[c]));
    check({n, "_wout"},  32'(wo),  32'(m_sh));
  endtask

  // one clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    logic [23:0] r;
    bit o;
    @(posedge clk);
    if (rst) begin
      m_sh = 8'd0; m_act = 8'd0; m_ifm = 8'd0; m_vld = 1'b0;
      for (int c = 0; c < 3; c++) begin
        m_ps[c] = 24'd0; m_ovf[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        o = 1'b0;
        if (vld) begin
          model_mac(m_act, x, p, cpw[c], csg[c], csat[c], r, o);
          m_ps[c] = r;
        end
        m_ovf[c] = (clr ? 1'b0 : m_ovf[c]) | o;
      end
      m_vld = vld;
      if (vld) m_ifm = x;
      if (w_swap) m_act = m_sh;
      if (w_load) m_sh = w_in;
    end
    #1;
    check_cfg("A", 0, psA, pvA, ifA, ivA, ovA, woA);
    check_cfg("B", 1, {8'd0, psB}, pvB, ifB, ivB, ovB, woB);
    check_cfg("C", 2, psC, pvC, ifC, ivC, ovC, woC);
  endtask

  task automatic idle();
    rst = 1'b0; w_load = 1'b0; w_swap = 1'b0; vld = 1'b0; clr = 1'b0;
    w_in = 8'd0; x = 8'd0; p = 24'd0;
  endtask

  task automatic load_swap(input logic [7:0] w);
    idle(); w_load = 1'b1; w_in = w; step();
    idle(); w_swap = 1'b1; step();
    idle();
  endtask

  logic [7:0] old_w [4];

  initial begin
    idle();
    c_load = 1'b0; c_swap = 1'b0; c_vld = 1'b0; c_w = 8'd0; c_x = 8'd0;

    // T1: two reset cycles with random inputs
    rst = 1'b1; w_load = 1'b1; w_swap = 1'b1; vld = 1'b1; clr = 1'b0;
    w_in = 8'($urandom); x = 8'($urandom); p = 24'($urandom);
    step();
    w_in = 8'($urandom); x = 8'($urandom); p = 24'($urandom);
    step();
    check("t1_psA", 32'(psA), 32'd0);
    check("t1_pvA", 32'(pvA), 32'd0);
    check("t1_ovA", 32'(ovA), 32'd0);
    check("t1_woA", 32'(woA), 32'd0);
    idle();

    // T2: -3 * 5 + 10 = -5
    load_swap(8'hFD);
    vld = 1'b1; x = 8'd5; p = 24'd10; step();
    check("t2_psA", 32'(psA), 32'hFFFFFB);
    check("t2_ovA", 32'(ovA), 32'd0);
    check("t2_ifA", 32'(ifA), 32'd5);
    idle(); step();
    check("t2_hold_psA", 32'(psA), 32'hFFFFFB);
    check("t2_hold_pvA", 32'(pvA), 32'd0);

    // T3: 16-bit signed saturation, then clear
    load_swap(8'd127);
    vld = 1'b1; x = 8'd127; p = 24'h007FFF; step();
    check("t3_psB", 32'(psB), 32'h7FFF);
    check("t3_ovB", 32'(ovB), 32'd1);
    idle(); clr = 1'b1; step();
    check("t3_clr_ovB", 32'(ovB), 32'd0);
    idle();

    // T4: unsigned wrap
    load_swap(8'hFF);
    vld = 1'b1; x = 8'hFF; p = 24'hFFFFFF; step();
    check("t4_psC", 32'(psC), 32'h00FE00);
    check("t4_ovC", 32'(ovC), 32'd1);
    // clear together with a fresh overflow: set wins
    clr = 1'b1; step();
    check("t4_setwins_ovC", 32'(ovC), 32'd1);
    idle(); clr = 1'b1; step();
    idle();

    // T5: swap concurrent with MAC uses the pre-swap weight
    load_swap(8'd2);
    w_load = 1'b1; w_in = 8'd7; step();
    idle(); w_swap = 1'b1; vld = 1'b1; x = 8'd3; step();
    check("t5_pre_swap", 32'(psA), 32'd6);
    idle(); vld = 1'b1; x = 8'd3; step();
    check("t5_post_swap", 32'(psA), 32'd21);
    idle();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      w_load = 1'($urandom_range(0, 1));
      w_swap = ($urandom_range(0, 3) == 0);
      vld    = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 7) == 0);
      w_in   = 8'($urandom);
      x      = 8'($urandom);
      p      = 24'($urandom);
      case ($urandom_range(0, 5))
        0: p = 24'h7FFFFF;
        1: p = 24'h800000;
        2: p = 24'hFFFFFF;
        3: p = 24'h007FFF;
        default: p = p;
      endcase
      step();
    end
    idle(); step();

    // T6: four-PE chain; preload old weights 6,7,8,9 top..bottom
    for (int i = 0; i < 4; i++) begin
      c_load = 1'b1; c_w = 8'(9 - i); step();
    end
    c_load = 1'b0; c_swap = 1'b1; step();
    c_swap = 1'b0;
    for (int k = 0; k < 4; k++) old_w[k] = 8'(6 + k);
    // load 1,2,3,4 while MACs run on the old weights
    for (int i = 0; i < 4; i++) begin
      c_load = 1'b1; c_w = 8'(i + 1); c_vld = 1'b1; c_x = 8'($urandom_range(1, 20));
      step();
      for (int k = 0; k < 4; k++)
        check($sformatf("t6_old_pe%0d", k), 32'(c_ps[k]), 32'(old_w[k] * c_x));
    end
    c_load = 1'b0; c_vld = 1'b0; c_swap = 1'b1; step();
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_shadow_pe%0d", k), 32'(c_wch[k+1]), 32'(4 - k));
    c_swap = 1'b0; c_vld = 1'b1; c_x = 8'd5; step();
    for (int k = 0; k < 4; k++)
      check($sformatf("t6_new_pe%0d", k), 32'(c_ps[k]), 32'((4 - k) * 5));
    c_vld = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
